acc_drain: RTL



---
 rtl/acc_drain_pkg.sv | 13 +
 rtl/sync_fifo.sv | 53 +++++
 rtl/acc_drain.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/acc_drain_pkg.sv
// Shared types for the accumulator drain: FSM states and the FIFO payload word.
package acc_drain_pkg;

  localparam int ACC_DATA_W = 32;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} drain_state_t;

  typedef struct packed {
    logic                  last;
    logic [ACC_DATA_W-1:0] data;
  } payload_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; push and pop may share a cycle, including when full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/acc_drain.sv
// Sweeps an address window of the accumulator, streams words out with credit-limited
// reads (start->m_valid in 3 cycles), optionally zeroing each location as it returns.
module acc_drain import acc_drain_pkg::*; #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = ACC_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic                  clear_en,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_rdata,
  output logic                  wr_en,
  output logic                  wr_we,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_wdata,
  output logic                  acc_mode,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready
);

  localparam int IW = $clog2(RD_LAT + 2);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  drain_state_t          state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   issued;
  logic                  clr_q;
  logic [IW-1:0]         inflight;

  logic                  pipe_vld  [RD_LAT];
  logic [ADDR_WIDTH-1:0] pipe_addr [RD_LAT];
  logic                  pipe_last [RD_LAT];

  logic                  ret_vld;
  logic [ADDR_WIDTH-1:0] ret_addr;
  logic                  ret_last;
  logic                  issue_last;
  logic                  credit;
  logic                  pop;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  payload_t              push_word;
  payload_t              head;

  assign ret_vld  = pipe_vld[RD_LAT-1];
  assign ret_addr = pipe_addr[RD_LAT-1];
  assign ret_last = pipe_last[RD_LAT-1];

  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;
  assign m_data  = m_valid ? head.data : '0;
  assign m_last  = m_valid && head.last;

  // Reads still in the pipeline already own a FIFO slot; a pop this cycle frees one.
  assign credit     = (32'(fifo_count) + 32'(inflight)) < (32'(FIFO_DEPTH) + 32'(pop));
  assign issue_last = ((issued + (ADDR_WIDTH+1)'(1)) == len_q);
  assign rd_en      = (state == ISSUE) && (issued != len_q) && credit;
  assign rd_addr    = base_q + issued[ADDR_WIDTH-1:0];

  assign wr_en    = ret_vld && clr_q;
  assign wr_we    = wr_en;
  assign wr_addr  = ret_addr;
  assign wr_wdata = '0;
  assign acc_mode = 1'b0;

  assign push_word = '{last: ret_last, data: rd_rdata};

  sync_fifo #(
    .WIDTH($bits(payload_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (ret_vld),
    .push_data (push_word),
    .pop       (pop),
    .pop_data  (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_vld[i]  <= 1'b0;
        pipe_addr[i] <= '0;
        pipe_last[i] <= 1'b0;
      end
      inflight <= '0;
    end else begin
      pipe_vld[0]  <= rd_en;
      pipe_addr[0] <= rd_addr;
      pipe_last[0] <= issue_last;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
      case ({rd_en, ret_vld})
        2'b10:   inflight <= inflight + IW'(1);
        2'b01:   inflight <= inflight - IW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      base_q <= '0;
      len_q  <= '0;
      clr_q  <= 1'b0;
      issued <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_q <= base_addr;
            len_q  <= len;
            clr_q  <= clear_en;
            issued <= '0;
            if (len != '0) begin
              busy  <= 1'b1;
              state <= ISSUE;
            end else begin
              done  <= 1'b1;
              state <= FIN;
            end
          end
        end
        ISSUE: begin
          if (rd_en) begin
            issued <= issued + (ADDR_WIDTH+1)'(1);
            if (issue_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Leave once the final word is handshaking (or already gone) and nothing is in flight.
          if (inflight == '0 &&
              (fifo_count == '0 || (fifo_count == CW'(1) && pop))) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
